// File: rtl/demux1_4_wrbank_pkg.sv
// Shared lane/counter widths and types for the 1:4 write-distribution bank.
package demux_pkg;
  localparam int NUM_LANES = 4;
  localparam int SEL_W     = 2;
  localparam int CNT_W     = 8;

  typedef logic [SEL_W-1:0] lane_sel_t;
  typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/demux1_4_wrbank_dec.sv
// decoder2_4: combinational 2-to-4 one-hot decoder with enable; all zeros when disabled.
module decoder2_4
  import demux_pkg::*;
(
  input  logic                 en,
  input  lane_sel_t            sel,
  output logic [NUM_LANES-1:0] oh
);

  // One-hot decode of the lane select, gated by the enable
  always_comb begin
    oh = 4'b0000;
    if (en) begin
      case (sel)
        2'd0:    oh = 4'b0001;
        2'd1:    oh = 4'b0010;
        2'd2:    oh = 4'b0100;
        2'd3:    oh = 4'b1000;
        default: oh = 4'b0000;
      endcase
    end else begin
      oh = 4'b0000;
    end
  end

endmodule

// File: rtl/demux1_4_wrbank.sv
// demux1_4_wrbank: two-stage 1:4 write distributor into four lane registers with
// per-lane valid flags and saturating commit counters. Optional WRBANK_PARITY_EN.
module demux1_4_wrbank
  import demux_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int SAT_MAX = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [SEL_W-1:0]             wr_sel,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         clr_en,
  input  logic [SEL_W-1:0]             clr_sel,
  output logic [NUM_LANES*WIDTH-1:0]   q,
  output logic [NUM_LANES-1:0]         lane_valid,
  output logic                         pend_valid,
  output logic [SEL_W-1:0]             pend_sel,
  output logic [WIDTH-1:0]             pend_data,
  output logic [NUM_LANES*CNT_W-1:0]   wr_cnt
`ifdef WRBANK_PARITY_EN
  ,
  output logic [NUM_LANES-1:0]         par_err
`endif
);

  localparam cnt_t SAT_LIM = cnt_t'(SAT_MAX);

  logic                             pend_valid_q, pend_valid_d;
  lane_sel_t                        pend_sel_q, pend_sel_d;
  logic [WIDTH-1:0]                 pend_data_q, pend_data_d;
  logic [NUM_LANES-1:0][WIDTH-1:0]  q_q, q_d;
  logic [NUM_LANES-1:0]             valid_q, valid_d;
  cnt_t [NUM_LANES-1:0]             cnt_q, cnt_d;
  logic [NUM_LANES-1:0]             commit_oh_s, clr_oh_s;

`ifdef WRBANK_PARITY_EN
  logic [NUM_LANES-1:0]             par_q, par_d;
  logic [NUM_LANES-1:0]             par_err_q, par_err_d;

  function automatic logic even_par(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction
`endif

  decoder2_4 u_commit_dec (.en(pend_valid_q), .sel(pend_sel_q), .oh(commit_oh_s));
  decoder2_4 u_clear_dec  (.en(clr_en),       .sel(clr_sel),    .oh(clr_oh_s));

  // Next-state: stage-1 capture, stage-2 commit; a clear beats a commit on the same lane
  always_comb begin
    pend_valid_d = wr_en;
    if (wr_en) begin
      pend_sel_d  = wr_sel;
      pend_data_d = wr_data;
    end else begin
      pend_sel_d  = pend_sel_q;
      pend_data_d = pend_data_q;
    end
    q_d     = q_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
`ifdef WRBANK_PARITY_EN
    par_d = par_q;
    for (int i = 0; i < NUM_LANES; i++) begin
      par_err_d[i] = ^{q_q[i], par_q[i]};
    end
`endif
    for (int i = 0; i < NUM_LANES; i++) begin
      if (clr_oh_s[i]) begin
        q_d[i]     = {WIDTH{1'b0}};
        valid_d[i] = 1'b0;
`ifdef WRBANK_PARITY_EN
        par_d[i]   = 1'b0;
`endif
      end else if (commit_oh_s[i]) begin
        q_d[i]     = pend_data_q;
        valid_d[i] = 1'b1;
`ifdef WRBANK_PARITY_EN
        par_d[i]   = even_par(pend_data_q);
`endif
        if (cnt_q[i] < SAT_LIM) begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end else begin
          cnt_d[i] = cnt_q[i];
        end
      end else begin
        q_d[i] = q_q[i];
      end
    end
  end

  // State registers; reset discards any pending write
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid_q <= 1'b0;
      pend_sel_q   <= 2'd0;
      pend_data_q  <= {WIDTH{1'b0}};
      q_q          <= {(NUM_LANES*WIDTH){1'b0}};
      valid_q      <= 4'b0000;
      cnt_q        <= {(NUM_LANES*CNT_W){1'b0}};
`ifdef WRBANK_PARITY_EN
      par_q        <= 4'b0000;
      par_err_q    <= 4'b0000;
`endif
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_sel_q   <= pend_sel_d;
      pend_data_q  <= pend_data_d;
      q_q          <= q_d;
      valid_q      <= valid_d;
      cnt_q        <= cnt_d;
`ifdef WRBANK_PARITY_EN
      par_q        <= par_d;
      par_err_q    <= par_err_d;
`endif
    end
  end

  assign q          = q_q;
  assign lane_valid = valid_q;
  assign pend_valid = pend_valid_q;
  assign pend_sel   = pend_sel_q;
  assign pend_data  = pend_data_q;
  assign wr_cnt     = cnt_q;
`ifdef WRBANK_PARITY_EN
  assign par_err    = par_err_q;
`endif

endmodule

// File: tb/tb_demux1_4_wrbank.sv
// Self-checking bench for demux1_4_wrbank: directed scenarios plus random traffic
// against a lane-array reference model. Parity test runs when WRBANK_PARITY_EN is set.
module tb_demux1_4_wrbank;
  localparam int W = 64;

  logic           clk = 1'b0;
  logic           reset, wr_en, clr_en;
  logic [1:0]     wr_sel, clr_sel;
  logic [W-1:0]   wr_data;
  logic [4*W-1:0] q;
  logic [3:0]     lane_valid;
  logic           pend_valid;
  logic [1:0]     pend_sel;
  logic [W-1:0]   pend_data;
  logic [31:0]    wr_cnt;
`ifdef WRBANK_PARITY_EN
  logic [3:0]     par_err;
`endif

  demux1_4_wrbank #(.WIDTH(W), .SAT_MAX(255)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .clr_en(clr_en), .clr_sel(clr_sel), .q(q), .lane_valid(lane_valid),
    .pend_valid(pend_valid), .pend_sel(pend_sel), .pend_data(pend_data), .wr_cnt(wr_cnt)
`ifdef WRBANK_PARITY_EN
    , .par_err(par_err)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: lane contents, flags, commit counts, and the one in-flight write
  logic [W-1:0] m_q [4];
  bit           m_valid [4];
  int           m_cnt [4];
  bit           m_pv;
  int           m_ps;
  logic [W-1:0] m_pd;

  int n_chk = 0;
  int n_pass = 0;

  function automatic logic [4*W-1:0] exp_q();
    logic [4*W-1:0] r;
    for (int i = 0; i < 4; i++) r[i*W +: W] = m_q[i];
    return r;
  endfunction

  function automatic logic [31:0] exp_cnt();
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = m_cnt[i][7:0];
    return r;
  endfunction

  function automatic logic [3:0] exp_valid();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = m_valid[i];
    return r;
  endfunction

  // Advance one clock, apply the spec rules to the model, then settle before sampling
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 4; i++) begin m_q[i] = '0; m_valid[i] = 0; m_cnt[i] = 0; end
      m_pv = 0; m_ps = 0; m_pd = '0;
    end else begin
      if (m_pv && !(clr_en && int'(clr_sel) == m_ps)) begin
        m_q[m_ps] = m_pd; m_valid[m_ps] = 1;
        m_cnt[m_ps] = (m_cnt[m_ps] >= 255) ? 255 : m_cnt[m_ps] + 1;
      end
      if (clr_en) begin m_q[clr_sel] = '0; m_valid[clr_sel] = 0; end
      m_pv = wr_en;
      if (wr_en) begin m_ps = int'(wr_sel); m_pd = wr_data; end
    end
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; clr_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_en = 1'b1; wr_sel = 2'd2; wr_data = 64'hAA; clr_en = 1'b0; clr_sel = 2'd0;
    tick(); tick();
    n_chk++; if (q !== '0) $display("FAIL reset_q got=%h exp=0", q); else n_pass++;
    n_chk++; if (lane_valid !== 4'b0000) $display("FAIL reset_valid got=%b exp=0000", lane_valid); else n_pass++;
    n_chk++; if (pend_valid !== 1'b0 || pend_sel !== 2'd0 || pend_data !== '0)
      $display("FAIL reset_pend got=%b/%0d/%h exp=0/0/0", pend_valid, pend_sel, pend_data); else n_pass++;
    n_chk++; if (wr_cnt !== 32'd0) $display("FAIL reset_cnt got=%h exp=0", wr_cnt); else n_pass++;
    reset = 1'b0; idle(); tick(); tick();
    n_chk++; if (lane_valid[2] !== 1'b0 || q[2*W +: W] !== '0)
      $display("FAIL reset_discard got=%b/%h exp=0/0", lane_valid[2], q[2*W +: W]); else n_pass++;
  endtask

  task automatic test_latency();
    wr_en = 1'b1; wr_sel = 2'd1; wr_data = 64'h1234;
    tick();
    n_chk++; if (pend_valid !== 1'b1 || pend_sel !== 2'd1 || pend_data !== 64'h1234)
      $display("FAIL lat_pend got=%b/%0d/%h exp=1/1/1234", pend_valid, pend_sel, pend_data); else n_pass++;
    n_chk++; if (q[W +: W] !== '0) $display("FAIL lat_early got=%h exp=0", q[W +: W]); else n_pass++;
    idle(); tick();
    n_chk++; if (q[W +: W] !== 64'h1234) $display("FAIL lat_q got=%h exp=1234", q[W +: W]); else n_pass++;
    n_chk++; if (lane_valid !== 4'b0010) $display("FAIL lat_valid got=%b exp=0010", lane_valid); else n_pass++;
    n_chk++; if (wr_cnt[15:8] !== 8'd1 || pend_valid !== 1'b0)
      $display("FAIL lat_cnt got=%0d/%b exp=1/0", wr_cnt[15:8], pend_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [1:0] lanes [3];
    lanes[0] = 2'd3; lanes[1] = 2'd3; lanes[2] = 2'd0;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_sel = lanes[i]; wr_data = 64'(5 + i);
      tick();
    end
    idle(); tick();
    n_chk++; if (q[3*W +: W] !== 64'd6 || q[0 +: W] !== 64'd7)
      $display("FAIL b2b_q got=%0d/%0d exp=6/7", q[3*W +: W], q[0 +: W]); else n_pass++;
    n_chk++; if (wr_cnt[31:24] !== 8'd2) $display("FAIL b2b_cnt got=%0d exp=2", wr_cnt[31:24]); else n_pass++;
    n_chk++; if (q[W +: W] !== 64'h1234 || q[2*W +: W] !== '0 || lane_valid !== 4'b1011)
      $display("FAIL b2b_others got=%h/%h/%b exp=1234/0/1011", q[W +: W], q[2*W +: W], lane_valid); else n_pass++;
  endtask

  task automatic test_clear();
    logic [7:0] c2;
    wr_en = 1'b1; wr_sel = 2'd2; wr_data = 64'h55; tick();
    c2 = wr_cnt[23:16];
    wr_en = 1'b0; clr_en = 1'b1; clr_sel = 2'd2; tick();
    idle();
    n_chk++; if (q[2*W +: W] !== '0 || lane_valid[2] !== 1'b0 || wr_cnt[23:16] !== c2)
      $display("FAIL clr_same got=%h/%b/%0d exp=0/0/%0d", q[2*W +: W], lane_valid[2], wr_cnt[23:16], c2); else n_pass++;
    // commit to lane 0 while lane 1 is cleared on the same edge
    wr_en = 1'b1; wr_sel = 2'd0; wr_data = 64'hBEEF; tick();
    wr_en = 1'b0; clr_en = 1'b1; clr_sel = 2'd1; tick();
    idle();
    n_chk++; if (q[0 +: W] !== 64'hBEEF || q[W +: W] !== '0 || lane_valid !== 4'b1001)
      $display("FAIL clr_diff got=%h/%h/%b exp=beef/0/1001", q[0 +: W], q[W +: W], lane_valid); else n_pass++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      wr_en = 1'($urandom_range(0, 3) != 0); wr_sel = 2'($urandom);
      wr_data = {$urandom, $urandom};
      clr_en = 1'($urandom_range(0, 4) == 0); clr_sel = 2'($urandom);
      tick();
      n_chk++; if (q !== exp_q() || lane_valid !== exp_valid() || wr_cnt !== exp_cnt() || pend_valid !== m_pv)
        $display("FAIL rand_state cyc=%0d got=%b/%h exp=%b/%h", n, lane_valid, wr_cnt, exp_valid(), exp_cnt()); else n_pass++;
      if (m_pv) begin
        n_chk++; if (int'(pend_sel) != m_ps || pend_data !== m_pd)
          $display("FAIL rand_pend cyc=%0d got=%0d/%h exp=%0d/%h", n, pend_sel, pend_data, m_ps, m_pd); else n_pass++;
      end
    end
    idle(); tick();
  endtask

  task automatic test_saturation();
    logic [W-1:0] last;
    last = '0;
    for (int n = 0; n < 260; n++) begin
      wr_en = 1'b1; wr_sel = 2'd0; last = {$urandom, $urandom}; wr_data = last;
      tick();
    end
    idle(); tick();
    n_chk++; if (wr_cnt[7:0] !== 8'd255) $display("FAIL sat_cnt got=%0d exp=255", wr_cnt[7:0]); else n_pass++;
    n_chk++; if (q[0 +: W] !== last) $display("FAIL sat_q got=%h exp=%h", q[0 +: W], last); else n_pass++;
    n_chk++; if (wr_cnt !== exp_cnt()) $display("FAIL sat_all got=%h exp=%h", wr_cnt, exp_cnt()); else n_pass++;
  endtask

`ifdef WRBANK_PARITY_EN
  task automatic test_parity();
    logic flip;
    wr_en = 1'b1; wr_sel = 2'd1; wr_data = 64'h0F0F_0000_1234_0007; tick();
    idle(); tick(); tick();
    n_chk++; if (par_err !== 4'b0000) $display("FAIL par_clean got=%b exp=0000", par_err); else n_pass++;
    flip = ~dut.q_q[1][5];
    force dut.q_q[1][5] = flip;
    #1 release dut.q_q[1][5];
    tick();
    n_chk++; if (par_err !== 4'b0010) $display("FAIL par_err got=%b exp=0010", par_err); else n_pass++;
    clr_en = 1'b1; clr_sel = 2'd1; tick(); idle(); tick();
    m_q[1] = '0;
    n_chk++; if (par_err !== 4'b0000) $display("FAIL par_cleared got=%b exp=0000", par_err); else n_pass++;
  endtask
`endif

  initial begin
    for (int i = 0; i < 4; i++) begin m_q[i] = '0; m_valid[i] = 0; m_cnt[i] = 0; end
    m_pv = 0; m_ps = 0; m_pd = '0;
    @(negedge clk);
    test_reset();
    test_latency();
    test_back_to_back();
    test_clear();
    test_random();
    test_saturation();
`ifdef WRBANK_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
